// File: rtl/ad9517_spi_slave.sv
// AD9517 serial-control-port responder: byte-wide register bank behind a mode-0 SPI slave.
// Optional AD9517_SPI_SOFT_RESET_EN: writing D5=1 to address 0 clears the bank.
module ad9517_spi_slave #(
    parameter int unsigned ADDR_W      = 9,
    parameter logic [12:0] ID_ADDR     = 13'h003,
    parameter logic [7:0]  ID_VALUE    = 8'h53,
    parameter logic [12:0] UPDATE_ADDR = 13'h232
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sclk,
    input  logic        i_csn,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_miso_oe,
    output logic        o_reg_wr,
    output logic [12:0] o_reg_addr,
    output logic [7:0]  o_reg_wdata,
    output logic        o_update,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StInstr, StData, StEnd} state_e;

    state_e state_q, state_d;

    // [0] metastable, [1] synchronised, [2] edge-detect history; free-running through reset
    logic [2:0] sclk_sr, csn_sr, mosi_sr;
    logic       sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_s, sclk_act;

    logic [3:0]  bit_cnt_q;
    logic [14:0] shift_q;
    logic        rw_q, stream_q, reload_q;
    logic [1:0]  bytes_left_q;
    logic [12:0] addr_q;
    logic [7:0]  tx_q;
    logic [7:0]  bank_q [DEPTH];

    logic        instr_done, byte_done, last_byte, wr_commit, abort;
    logic [15:0] instr_word;
    logic [7:0]  wdata, rd_byte, tx_src, bank_wdata;
    logic [12:0] rd_addr;
    logic        bank_we, soft_clr;

    always_ff @(posedge clk) begin
        sclk_sr <= {sclk_sr[1:0], i_sclk};
        csn_sr  <= {csn_sr[1:0], i_csn};
        mosi_sr <= {mosi_sr[1:0], i_mosi};
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign csn_rise  = csn_sr[1] & ~csn_sr[2];
    assign csn_fall  = ~csn_sr[1] & csn_sr[2];
    assign mosi_s    = mosi_sr[2];
    assign sclk_act  = sclk_rise & ~csn_rise & ~csn_fall;

    assign instr_word = {shift_q, mosi_s};
    assign wdata      = {shift_q[6:0], mosi_s};
    assign rd_addr    = (state_q == StInstr) ? instr_word[12:0] : addr_q;
    assign tx_src     = reload_q ? rd_byte : tx_q;

    always_comb begin
        rd_byte = 8'h00;
        if (rd_addr == ID_ADDR) begin
            rd_byte = ID_VALUE;
        end else if ((rd_addr >> ADDR_W) == '0) begin
            rd_byte = bank_q[rd_addr[ADDR_W-1:0]];
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; a CSn fall from any state restarts the instruction phase
    always_comb begin
        state_d = state_q;
        if (csn_fall) begin
            state_d = StInstr;
        end else if (csn_rise) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StInstr: if (instr_done) state_d = StData;
                StData:  if (byte_done && last_byte) state_d = StEnd;
                default: ;
            endcase
        end
    end

    // FSM: decoded strobes and outputs
    always_comb begin
        instr_done = (state_q == StInstr) && sclk_act && (bit_cnt_q == 4'd15);
        byte_done  = (state_q == StData) && sclk_act && (bit_cnt_q == 4'd7);
        last_byte  = !stream_q && (bytes_left_q == 2'd1);
        wr_commit  = byte_done && !rw_q;
        abort      = csn_rise && ((state_q == StInstr) ||
                                  ((state_q == StData) && (bit_cnt_q != 4'd0)));
        o_busy     = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rw_q         <= 1'b0;
            stream_q     <= 1'b0;
            bytes_left_q <= '0;
            addr_q       <= '0;
            tx_q         <= '0;
            reload_q     <= 1'b0;
            o_miso       <= 1'b0;
            o_miso_oe    <= 1'b0;
            o_reg_wr     <= 1'b0;
            o_reg_addr   <= '0;
            o_reg_wdata  <= '0;
            o_update     <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_reg_wr    <= wr_commit;
            o_update    <= wr_commit && (addr_q == UPDATE_ADDR) && wdata[0];
            o_frame_err <= abort;
            if (wr_commit) begin
                o_reg_addr  <= addr_q;
                o_reg_wdata <= wdata;
            end
            if (csn_fall) begin
                bit_cnt_q <= '0;
                o_miso_oe <= 1'b0;
                reload_q  <= 1'b0;
            end else if (csn_rise) begin
                bit_cnt_q <= '0;
                o_miso_oe <= 1'b0;
            end else if (sclk_act && (state_q inside {StInstr, StData})) begin
                shift_q   <= {shift_q[13:0], mosi_s};
                bit_cnt_q <= (instr_done || byte_done) ? 4'd0 : bit_cnt_q + 4'd1;
                if (instr_done) begin
                    rw_q         <= instr_word[15];
                    stream_q     <= &instr_word[14:13];
                    bytes_left_q <= instr_word[14:13] + 2'd1;
                    addr_q       <= instr_word[12:0];
                    if (instr_word[15]) begin
                        tx_q      <= rd_byte;
                        o_miso_oe <= 1'b1;
                    end
                end
                if (byte_done) begin
                    addr_q       <= addr_q - 13'd1;
                    bytes_left_q <= bytes_left_q - 2'd1;
                    reload_q     <= rw_q;
                end
            end else if (sclk_fall && (state_q == StData) && rw_q) begin
                o_miso   <= tx_src[7];
                tx_q     <= {tx_src[6:0], 1'b0};
                reload_q <= 1'b0;
            end
        end
    end

    assign bank_we = wr_commit && ((addr_q >> ADDR_W) == '0) && (addr_q != ID_ADDR);

    always_comb begin
        bank_wdata = wdata;
        if (addr_q == UPDATE_ADDR) bank_wdata[0] = 1'b0;
`ifdef AD9517_SPI_SOFT_RESET_EN
        if (addr_q == 13'h000) bank_wdata[5] = 1'b0;
`endif
    end

`ifdef AD9517_SPI_SOFT_RESET_EN
    logic soft_clr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            soft_clr_q <= 1'b0;
        end else begin
            soft_clr_q <= wr_commit && (addr_q == 13'h000) && wdata[5];
        end
    end
    assign soft_clr = soft_clr_q;
`else
    assign soft_clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || soft_clr) begin
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= 8'h00;
        end else if (bank_we) begin
            bank_q[addr_q[ADDR_W-1:0]] <= bank_wdata;
        end
    end

endmodule

// File: tb/tb_ad9517_spi_slave.sv
// Self-checking bench for ad9517_spi_slave: SPI master model, write/read scoreboards.
module tb_ad9517_spi_slave;

    localparam int HALF = 60;

    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe, reg_wr, update, frame_err, busy;
    logic [12:0] reg_addr;
    logic [7:0]  reg_wdata;

    int n_vec = 0, n_err = 0, n_upd = 0, n_ferr = 0;
    logic [20:0] exp_wr[$], obs_wr[$];
    logic [7:0]  exp_rd[$];

    ad9517_spi_slave dut (
        .clk        (clk),
        .rst        (rst),
        .i_sclk     (sclk),
        .i_csn      (csn),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .o_miso_oe  (miso_oe),
        .o_reg_wr   (reg_wr),
        .o_reg_addr (reg_addr),
        .o_reg_wdata(reg_wdata),
        .o_update   (update),
        .o_frame_err(frame_err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr) obs_wr.push_back({reg_addr, reg_wdata});
        if (update) n_upd++;
        if (frame_err) n_ferr++;
    end

    task automatic spi_bit(input logic b, output logic r, output logic oe);
        mosi = b;
        #(HALF);
        sclk = 1'b1;
        r    = miso;
        oe   = miso_oe;
        #(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_end();
        #(HALF);
        csn  = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [63:0] tx, input int n,
                             output logic [63:0] rx, output logic [63:0] oe);
        logic r, e;
        rx = '0;
        oe = '0;
        @(negedge clk);
        csn = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(tx[i], r, e);
            rx = {rx[62:0], r};
            oe = {oe[62:0], e};
        end
        spi_end();
    endtask

    task automatic spi_write(input logic [12:0] a, input logic [1:0] w, input int nb,
                             input logic [31:0] data);
        logic [63:0] tx, rx, oe;
        tx = 64'({1'b0, w, a}) << (8 * nb);
        tx = tx | 64'(data);
        for (int i = 0; i < nb; i++) exp_wr.push_back({a - 13'(i), data[8*(nb-1-i) +: 8]});
        spi_frame(tx, 16 + 8 * nb, rx, oe);
    endtask

    task automatic spi_read(input logic [12:0] a, input logic [1:0] w, input int nb,
                            output logic [31:0] rx, output logic [31:0] oe_d,
                            output logic [15:0] oe_i);
        logic [63:0] tx, rx64, oe64;
        tx = 64'({1'b1, w, a}) << (8 * nb);
        spi_frame(tx, 16 + 8 * nb, rx64, oe64);
        rx   = rx64[31:0];
        oe_d = oe64[31:0];
        oe_i = oe64[8*nb +: 16];
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso got %b want 0", miso); end
        n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got %b want 0", miso_oe); end
        n_vec++; if (reg_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got %b want 0", reg_wr); end
        n_vec++; if (update !== 1'b0) begin n_err++; $display("FAIL reset_update got %b want 0", update); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read_id();
        logic [31:0] rx, oe;
        logic [15:0] oei;
        logic [7:0]  e;
        exp_rd.push_back(8'h53);
        spi_read(13'h003, 2'b00, 1, rx, oe, oei);
        e = exp_rd.pop_front();
        n_vec++; if (rx[7:0] !== e) begin n_err++; $display("FAIL read_id_data got %h want %h", rx[7:0], e); end
        n_vec++; if (oe[7:0] !== 8'hFF || oei !== 16'h0000) begin
            n_err++; $display("FAIL read_id_oe got %h/%h want ff/0000", oe[7:0], oei);
        end
        n_vec++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL read_id_oe_off got %b want 0", miso_oe); end
        n_vec++; if (obs_wr.size() != 0) begin
            n_err++; $display("FAIL read_id_no_write got %0d writes want 0", obs_wr.size());
            obs_wr.delete();
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] rx, oe;
        logic [15:0] oei;
        logic [20:0] e, g;
        logic [7:0]  eb;
        spi_write(13'h01C, 2'b00, 1, 32'h01);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_vec++;
            if (obs_wr.size() == 0) begin n_err++; $display("FAIL wb_write got none want %h", e); end
            else begin g = obs_wr.pop_front();
                if (g !== e) begin n_err++; $display("FAIL wb_write got %h want %h", g, e); end end
        end
        n_vec++; if (obs_wr.size() != 0) begin n_err++; $display("FAIL wb_extra got %0d want 0", obs_wr.size()); obs_wr.delete(); end
        exp_rd.push_back(8'h01);
        spi_read(13'h01C, 2'b00, 1, rx, oe, oei);
        eb = exp_rd.pop_front();
        n_vec++; if (rx[7:0] !== eb) begin n_err++; $display("FAIL wb_read got %h want %h", rx[7:0], eb); end
    endtask

    task automatic test_multi_byte();
        logic [31:0] rx, oe;
        logic [15:0] oei;
        logic [20:0] e, g;
        logic [7:0]  eb;
        int f0;
        spi_write(13'h0F1, 2'b01, 2, 32'hAA55);
        f0 = n_ferr;
        spi_write(13'h001, 2'b11, 3, 32'h111233);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_vec++;
            if (obs_wr.size() == 0) begin n_err++; $display("FAIL multi_write got none want %h", e); end
            else begin g = obs_wr.pop_front();
                if (g !== e) begin n_err++; $display("FAIL multi_write got %h want %h", g, e); end end
        end
        n_vec++; if (obs_wr.size() != 0) begin n_err++; $display("FAIL multi_extra got %0d want 0", obs_wr.size()); obs_wr.delete(); end
        n_vec++; if (n_ferr != f0) begin n_err++; $display("FAIL stream_ferr got %0d want %0d", n_ferr, f0); end
        exp_rd.push_back(8'hAA); exp_rd.push_back(8'h55); exp_rd.push_back(8'h00);
        spi_read(13'h0F1, 2'b10, 3, rx, oe, oei);
        for (int i = 0; i < 3; i++) begin
            eb = exp_rd.pop_front(); n_vec++;
            if (rx[8*(2-i) +: 8] !== eb) begin n_err++; $display("FAIL multi_read_%0d got %h want %h", i, rx[8*(2-i) +: 8], eb); end
        end
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h12); exp_rd.push_back(8'h00);
        spi_read(13'h001, 2'b10, 3, rx, oe, oei);
        for (int i = 0; i < 3; i++) begin
            eb = exp_rd.pop_front(); n_vec++;
            if (rx[8*(2-i) +: 8] !== eb) begin n_err++; $display("FAIL wrap_read_%0d got %h want %h", i, rx[8*(2-i) +: 8], eb); end
        end
    endtask

    task automatic test_update_id();
        logic [31:0] rx, oe;
        logic [15:0] oei;
        logic [20:0] e, g;
        logic [7:0]  eb;
        int u0;
        u0 = n_upd;
        spi_write(13'h232, 2'b00, 1, 32'h01);
        spi_write(13'h003, 2'b00, 1, 32'h12);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_vec++;
            if (obs_wr.size() == 0) begin n_err++; $display("FAIL upd_write got none want %h", e); end
            else begin g = obs_wr.pop_front();
                if (g !== e) begin n_err++; $display("FAIL upd_write got %h want %h", g, e); end end
        end
        n_vec++; if (obs_wr.size() != 0) begin n_err++; $display("FAIL upd_extra got %0d want 0", obs_wr.size()); obs_wr.delete(); end
        n_vec++; if (n_upd != u0 + 1) begin n_err++; $display("FAIL update_pulses got %0d want %0d", n_upd - u0, 1); end
        exp_rd.push_back(8'h00);
        spi_read(13'h232, 2'b00, 1, rx, oe, oei);
        eb = exp_rd.pop_front();
        n_vec++; if (rx[7:0] !== eb) begin n_err++; $display("FAIL update_readback got %h want %h", rx[7:0], eb); end
        exp_rd.push_back(8'h53);
        spi_read(13'h003, 2'b00, 1, rx, oe, oei);
        eb = exp_rd.pop_front();
        n_vec++; if (rx[7:0] !== eb) begin n_err++; $display("FAIL id_protect got %h want %h", rx[7:0], eb); end
    endtask

    task automatic test_abort();
        logic [23:0] tx;
        logic [31:0] rx, oe;
        logic [15:0] oei;
        logic [20:0] e, g;
        logic [7:0]  eb;
        logic        r, o;
        int f0;
        f0 = n_ferr;
        tx = 24'h0040A5;
        @(negedge clk);
        csn = 1'b0;
        for (int i = 23; i >= 4; i--) spi_bit(tx[i], r, o);
        spi_end();
        n_vec++; if (n_ferr != f0 + 1) begin n_err++; $display("FAIL abort_ferr got %0d want %0d", n_ferr - f0, 1); end
        n_vec++; if (obs_wr.size() != 0) begin n_err++; $display("FAIL abort_no_write got %0d want 0", obs_wr.size()); obs_wr.delete(); end
        exp_rd.push_back(8'h00);
        spi_read(13'h040, 2'b00, 1, rx, oe, oei);
        eb = exp_rd.pop_front();
        n_vec++; if (rx[7:0] !== eb) begin n_err++; $display("FAIL abort_readback got %h want %h", rx[7:0], eb); end
        spi_write(13'h040, 2'b00, 1, 32'h77);
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front(); n_vec++;
            if (obs_wr.size() == 0) begin n_err++; $display("FAIL post_abort_write got none want %h", e); end
            else begin g = obs_wr.pop_front();
                if (g !== e) begin n_err++; $display("FAIL post_abort_write got %h want %h", g, e); end end
        end
        exp_rd.push_back(8'h77);
        spi_read(13'h040, 2'b00, 1, rx, oe, oei);
        eb = exp_rd.pop_front();
        n_vec++; if (rx[7:0] !== eb) begin n_err++; $display("FAIL post_abort_read got %h want %h", rx[7:0], eb); end
        n_vec++; if (n_ferr != f0 + 1) begin n_err++; $display("FAIL post_abort_ferr got %0d want %0d", n_ferr - f0, 1); end
    endtask

    task automatic test_reset_mid_read();
        logic [18:0] tx;
        logic [31:0] rx, oe;
        logic [15:0] oei;
        logic [7:0]  eb;
        logic        r, o;
        int f0;
        f0 = n_ferr;
        tx = {16'hE003, 3'b000};
        @(negedge clk);
        csn = 1'b0;
        for (int i = 18; i >= 0; i--) spi_bit(tx[i], r, o);
        n_vec++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin
            n_err++; $display("FAIL mid_read_active got busy=%b oe=%b want 1/1", busy, miso_oe);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_vec++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            n_err++; $display("FAIL mid_read_reset got busy=%b oe=%b want 0/0", busy, miso_oe);
        end
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r, o);
        n_vec++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            n_err++; $display("FAIL post_reset_ignore got busy=%b oe=%b want 0/0", busy, miso_oe);
        end
        spi_end();
        n_vec++; if (n_ferr != f0 || obs_wr.size() != 0) begin
            n_err++; $display("FAIL post_reset_quiet got ferr=%0d wr=%0d want 0/0", n_ferr - f0, obs_wr.size());
            obs_wr.delete();
        end
        exp_rd.push_back(8'h53);
        spi_read(13'h003, 2'b00, 1, rx, oe, oei);
        eb = exp_rd.pop_front();
        n_vec++; if (rx[7:0] !== eb) begin n_err++; $display("FAIL post_reset_id got %h want %h", rx[7:0], eb); end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_write_readback();
        test_multi_byte();
        test_update_id();
        test_abort();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
